// File: rtl/mem_port_arbiter.sv
// Arbiter that lets the fetch and load/store stages share one single-ported memory.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts a stuck transaction and pulses err.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_wstrb,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

   stateT       state;
   logic        ownerIf;
   logic [3:0]  starveCnt;
   logic        dmWins;
   logic        respHit;
   logic        timeoutHit;
   logic [31:0] doneData;

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] toCnt;
`endif

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

   // Data wins as the older instruction unless fetch has already waited out its quota.
   assign dmWins = dm_req && !(if_req && (starveCnt == 4'(STARVE_LIMIT)));

   always_comb begin
      respHit    = (state == WAIT) && mem_rvalid;
      timeoutHit = 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeoutHit = ((state == ISSUE) || (state == WAIT)) &&
                   (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif
      doneData   = (respHit && !mem_we) ? mem_rdata : 32'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ownerIf   <= 1'b1;
         starveCnt <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         if_valid  <= 1'b0;
         dm_valid  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
         toCnt     <= '0;
         err       <= 1'b0;
`endif
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         if_rdata <= '0;
         dm_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
         err <= 1'b0;
         if ((state == ISSUE) || (state == WAIT)) toCnt <= toCnt + 1'b1;
         else                                     toCnt <= '0;
`endif
         case (state)
            IDLE: begin
               if (dmWins) begin
                  ownerIf   <= 1'b0;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_wstrb <= dm_wstrb;
                  if (if_req && (starveCnt < 4'(STARVE_LIMIT))) starveCnt <= starveCnt + 4'd1;
                  state     <= ISSUE;
               end else if (if_req) begin
                  ownerIf   <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_wstrb <= '0;
                  starveCnt <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: ;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
         // Completion (real response or watchdog abort) overrides the per-state updates.
         if (respHit || timeoutHit) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            if_valid <= ownerIf;
            dm_valid <= ~ownerIf;
            if (ownerIf) if_rdata <= doneData;
            else         dm_rdata <= doneData;
`ifdef ARB_TIMEOUT_EN
            err <= timeoutHit && !respHit;
`endif
         end
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign err = 1'b0;
`endif

endmodule
